cpsr_stack: RTL and testbench
=============================

Name: cpsr_stack

Overview:
- Parametrised condition-flag register for the processor datapath; successor to the three-flag status register.
- Holds FLAG_W flags with masked per-bit update and a DEPTH-entry save/restore stack for interrupt/call entry and exit.
- Evaluates a full 4-bit branch condition code and returns a registered take/not-take result to the branch unit.

Parameters:
- FLAG_W, 4, number of flag bits. Must be >= 4. Bit 0 = Z, bit 1 = V, bit 2 = N (sign), bit 3 = C. Bits 4 and up are user flags with no condition meaning.
- DEPTH, 4, shadow stack entries. Must be >= 1.
- FWD, 0, selects the flag value used for condition evaluation. 0 = current register value. 1 = next-state value (same-cycle update/pop forwarded).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- update  input  1  write flags_in into the flag register under flag_mask.
- flag_mask  input  FLAG_W  per-bit write enable for update.
- flags_in  input  FLAG_W  new flag values from the ALU.
- push  input  1  save the current flags onto the stack.
- pop  input  1  restore the flags from the top of the stack.
- clr_err  input  1  clear the sticky error flags.
- cond  input  4  condition code.
- cond_valid  input  1  evaluate cond this cycle.
- flags_out  output  FLAG_W  flag register.
- take  output  1  registered condition result.
- take_valid  output  1  take is valid this cycle.
- depth_cnt  output  $clog2(DEPTH+1)  number of occupied stack entries.
- full  output  1  depth_cnt == DEPTH.
- empty  output  1  depth_cnt == 0.
- ovf_err  output  1  sticky: push attempted while full.
- unf_err  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (asynchronous, takes effect immediately, overrides everything):
  - flags_out = 0, take = 0, take_valid = 0, depth_cnt = 0, empty = 1, full = 0, ovf_err = 0, unf_err = 0.
  - All stack entries cleared to 0.
  - A push or pop in flight when reset asserts is lost.
- Flag register next-state, in priority order:
  - Valid pop (not empty): flags <= stack[top]. update is ignored that cycle.
  - Else if update: flags <= (flags & ~flag_mask) | (flags_in & flag_mask).
  - Else: hold.
- Push:
  - If not full, stack[depth_cnt] <= the pre-edge flags value and depth_cnt increments.
  - An update in the same cycle still applies to the flag register; the stacked copy is the old value.
- Pop:
  - If not empty, depth_cnt decrements.
- push and pop in the same cycle, not empty (swap):
  - stack[top] <= the pre-edge flags, flags <= old stack[top], depth_cnt unchanged.
  - A swap is legal when full.
- push and pop in the same cycle, empty:
  - Both are ignored and unf_err is set.
- Push when full (no pop): ignored, ovf_err <= 1.
- Pop when empty (no push): ignored, unf_err <= 1.
- Sticky errors:
  - Cleared only by reset or by clr_err.
  - If clr_err coincides with a new error event, the error is set (set wins).
- full and empty are combinational decodes of depth_cnt.
- Condition evaluation:
  - Source is F = flags_out when FWD = 0, or the flag next-state when FWD = 1.
  - Codes:
    - 0 EQ: Z
    - 1 NE: !Z
    - 2 CS: C
    - 3 CC: !C
    - 4 MI: N
    - 5 PL: !N
    - 6 VS: V
    - 7 VC: !V
    - 8 HI: C & !Z
    - 9 LS: !C | Z
    - A GE: N == V
    - B LT: N != V
    - C GT: !Z & (N == V)
    - D LE: Z | (N != V)
    - E AL: 1
    - F NV: 0
  - Latency 1: take and take_valid register on the edge after cond_valid.
  - take_valid = 0 in any cycle following cond_valid = 0; take holds its last value.
  - Back-to-back cond_valid gives one result per cycle.
- User flag bits (4 and up) update, push and pop exactly like the condition flags but never affect take.

Test Plan:
- Reset mid-operation: push twice (depth_cnt = 2), assert reset between edges -> immediately flags_out = 0, depth_cnt = 0, empty = 1; the following pop sets unf_err = 1.
- Masked update, then evaluate: update with flags_in = 4'b1111, mask = 4'b0101 from 0 -> flags_out = 4'b0101 (Z = 1, N = 1). Then cond = 0 (EQ) -> take = 1 one cycle later; cond = C (GT) -> take = 0; cond = B (LT) -> take = 1.
- Push plus update in the same cycle: flags = 4'b0001, push + update(mask = F, in = 4'b1000) -> flags_out = 4'b1000, stack[0] = 4'b0001. Next cycle pop -> flags_out = 4'b0001, empty = 1.
- Full and overflow (DEPTH = 4): 5 pushes -> depth_cnt = 4, full = 1, ovf_err = 1, stack contents unchanged. Then clr_err -> ovf_err = 0. Then a swap while full -> depth_cnt stays 4, flags exchange with the top entry.
- Empty and underflow: pop when empty -> flags unchanged, unf_err = 1. Push + pop when empty -> ignored, unf_err = 1.
- Forwarding: with FWD = 1, update setting Z plus cond_valid with cond = 0 in the same cycle -> take = 1 next cycle. With FWD = 0 the same stimulus -> take = 0.

Source files
------------

// File: rtl/cpsr_stack_if.sv
// Bus bundle for the condition-flag register: ALU flag writes, stack
// save/restore controls, and the branch-condition query with its result.
//
// Handshake: there is no backpressure anywhere on this bus. Every control
// input is a single-cycle strobe that the register always accepts. cond_valid
// qualifies cond; the matching result appears on take exactly one cycle later,
// qualified by take_valid. A strobe that cannot be honoured (push when full,
// pop when empty) is dropped and reported through the sticky ovf_err/unf_err
// flags.
interface cpsr_stack_if #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4
);
  localparam int DW = $clog2(DEPTH + 1);

  logic              update;
  logic [FLAG_W-1:0] flag_mask;
  logic [FLAG_W-1:0] flags_in;
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [3:0]        cond;
  logic              cond_valid;
  logic [FLAG_W-1:0] flags_out;
  logic              take;
  logic              take_valid;
  logic [DW-1:0]     depth_cnt;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output update, flag_mask, flags_in, push, pop, clr_err, cond, cond_valid,
    input  flags_out, take, take_valid, depth_cnt, full, empty, ovf_err, unf_err
  );

  modport slave (
    input  update, flag_mask, flags_in, push, pop, clr_err, cond, cond_valid,
    output flags_out, take, take_valid, depth_cnt, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/cpsr_stack.sv
// Condition-flag register with masked update, a save/restore shadow stack
// for interrupt/call entry and exit, and a registered branch-condition
// evaluator. Flag bits: 0 = Z, 1 = V, 2 = N, 3 = C; higher bits are user
// flags that travel with the register but never affect take.
module cpsr_stack #(
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4,
  parameter bit FWD    = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  cpsr_stack_if.slave  bus
);
  localparam int DW = $clog2(DEPTH + 1);

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [FLAG_W-1:0] stack_q [DEPTH];
  logic [FLAG_W-1:0] stack_d [DEPTH];
  logic [DW-1:0]     depth_q, depth_d;
  logic              take_q, take_d;
  logic              take_valid_q, take_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              full_w, empty_w;
  logic              do_push, do_pop, do_swap;
  logic              ovf_ev, unf_ev;
  logic [DW-1:0]     top_idx;
  logic [FLAG_W-1:0] top_val;
  logic [FLAG_W-1:0] cond_src;

  // Evaluate a 4-bit condition code against {C, N, V, Z}.
  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic z, v, n, c;
    z = f[0];
    v = f[1];
    n = f[2];
    c = f[3];
    case (code)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = !z;
      4'h2:    eval_cond = c;
      4'h3:    eval_cond = !c;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = !n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = !v;
      4'h8:    eval_cond = c & !z;
      4'h9:    eval_cond = !c | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = !z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Decode stack occupancy and classify this cycle's push/pop request.
  always_comb begin
    full_w  = (depth_q == DW'(DEPTH));
    empty_w = (depth_q == '0);
    top_idx = depth_q - DW'(1);
    // A swap needs something to swap with; it is legal even when full.
    do_swap = bus.push & bus.pop & !empty_w;
    do_push = bus.push & !bus.pop & !full_w;
    do_pop  = bus.pop & !bus.push & !empty_w;
    ovf_ev  = bus.push & !bus.pop & full_w;
    // Covers both a lone pop and a push+pop while empty.
    unf_ev  = bus.pop & empty_w;
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (DW'(i) == top_idx) top_val = stack_q[i];
    end
  end

  // Next-state for flags, stack, occupancy, sticky errors and condition result.
  always_comb begin
    flags_d = flags_q;
    if (do_pop || do_swap) begin
      flags_d = top_val;
    end else if (bus.update) begin
      flags_d = (flags_q & ~bus.flag_mask) | (bus.flags_in & bus.flag_mask);
    end

    // The stacked copy is always the pre-edge flag value.
    for (int i = 0; i < DEPTH; i++) begin
      stack_d[i] = stack_q[i];
      if (do_push && (DW'(i) == depth_q)) stack_d[i] = flags_q;
      if (do_swap && (DW'(i) == top_idx)) stack_d[i] = flags_q;
    end

    depth_d = depth_q;
    if (do_push)     depth_d = depth_q + DW'(1);
    else if (do_pop) depth_d = depth_q - DW'(1);

    // New error events win over a coincident clear.
    ovf_d = (ovf_q & !bus.clr_err) | ovf_ev;
    unf_d = (unf_q & !bus.clr_err) | unf_ev;

    cond_src     = FWD ? flags_d : flags_q;
    take_valid_d = bus.cond_valid;
    take_d       = bus.cond_valid ? eval_cond(bus.cond, cond_src[3:0]) : take_q;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q      <= '0;
      depth_q      <= '0;
      take_q       <= 1'b0;
      take_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      flags_q      <= flags_d;
      depth_q      <= depth_d;
      take_q       <= take_d;
      take_valid_q <= take_valid_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign bus.flags_out  = flags_q;
  assign bus.take       = take_q;
  assign bus.take_valid = take_valid_q;
  assign bus.depth_cnt  = depth_q;
  assign bus.full       = full_w;
  assign bus.empty      = empty_w;
  assign bus.ovf_err    = ovf_q;
  assign bus.unf_err    = unf_q;
endmodule

// File: tb/tb_cpsr_stack.sv
// Bench for cpsr_stack: table of single-cycle vectors with hand-computed
// expected outputs, plus hand sequences for asynchronous reset and for
// condition-source forwarding (FWD = 0 vs FWD = 1 instances side by side).
module tb_cpsr_stack;
  localparam int FW = 4;
  localparam int DP = 4;
  localparam int NV = 34;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [31:0] exp_q[$];

  cpsr_stack_if #(.FLAG_W(FW), .DEPTH(DP)) b0 ();
  cpsr_stack_if #(.FLAG_W(FW), .DEPTH(DP)) b1 ();

  // The forwarding instance sees exactly the same stimulus.
  assign b1.update     = b0.update;
  assign b1.flag_mask  = b0.flag_mask;
  assign b1.flags_in   = b0.flags_in;
  assign b1.push       = b0.push;
  assign b1.pop        = b0.pop;
  assign b1.clr_err    = b0.clr_err;
  assign b1.cond       = b0.cond;
  assign b1.cond_valid = b0.cond_valid;

  cpsr_stack #(.FLAG_W(FW), .DEPTH(DP), .FWD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(b0.slave)
  );
  cpsr_stack #(.FLAG_W(FW), .DEPTH(DP), .FWD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1.slave)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       upd;
    logic [3:0] mask;
    logic [3:0] fin;
    logic       push;
    logic       pop;
    logic       clr;
    logic       cv;
    logic [3:0] cond;
    logic [3:0] e_flags;
    logic       e_take;
    logic       e_tv;
    logic [2:0] e_depth;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic upd, input logic [3:0] mask, input logic [3:0] fin,
                              input logic push, input logic pop, input logic clr,
                              input logic cv, input logic [3:0] cond,
                              input logic [3:0] flags, input logic take, input logic tv,
                              input logic [2:0] depth, input logic ovf, input logic unf);
    vec_t v;
    v.upd = upd; v.mask = mask; v.fin = fin; v.push = push; v.pop = pop; v.clr = clr;
    v.cv = cv; v.cond = cond; v.e_flags = flags; v.e_take = take; v.e_tv = tv;
    v.e_depth = depth; v.e_ovf = ovf; v.e_unf = unf;
    return v;
  endfunction

  // Expected word: {flags, take, take_valid, depth, full, empty, ovf, unf}.
  function automatic logic [31:0] pack_exp(input logic [3:0] flags, input logic take,
                                           input logic tv, input logic [2:0] depth,
                                           input logic ovf, input logic unf);
    logic full_e, empty_e;
    full_e  = (depth == 3'd4);
    empty_e = (depth == 3'd0);
    return {19'd0, flags, take, tv, depth, full_e, empty_e, ovf, unf};
  endfunction

  function automatic logic [31:0] obs0();
    return {19'd0, b0.flags_out, b0.take, b0.take_valid, b0.depth_cnt,
            b0.full, b0.empty, b0.ovf_err, b0.unf_err};
  endfunction

  function automatic logic [31:0] obs1();
    return {19'd0, b1.flags_out, b1.take, b1.take_valid, b1.depth_cnt,
            b1.full, b1.empty, b1.ovf_err, b1.unf_err};
  endfunction

  // Scoreboard compare against the oldest queued expectation.
  task automatic check(input string name, input logic [31:0] act);
    logic [31:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: no expected value queued, got %h", name, act);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", name, act, exp);
      end
    end
  endtask

  task automatic drive_idle();
    b0.update = 1'b0; b0.flag_mask = '0; b0.flags_in = '0;
    b0.push = 1'b0; b0.pop = 1'b0; b0.clr_err = 1'b0;
    b0.cond = 4'h0; b0.cond_valid = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    b0.update = v.upd; b0.flag_mask = v.mask; b0.flags_in = v.fin;
    b0.push = v.push; b0.pop = v.pop; b0.clr_err = v.clr;
    b0.cond = v.cond; b0.cond_valid = v.cv;
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //                upd mask  fin  psh pop clr cv cond   flags tk tv dp ovf unf
    vecs[0]  = mk(1, 4'h5, 4'hF, 0, 0, 0, 0, 4'h0, 4'h5, 0, 0, 0, 0, 0); // masked update
    vecs[1]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h0, 4'h5, 1, 1, 0, 0, 0); // EQ
    vecs[2]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'hC, 4'h5, 0, 1, 0, 0, 0); // GT
    vecs[3]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'hB, 4'h5, 1, 1, 0, 0, 0); // LT
    vecs[4]  = mk(0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'h5, 1, 0, 0, 0, 0); // take holds
    vecs[5]  = mk(1, 4'hF, 4'h1, 0, 0, 0, 1, 4'hE, 4'h1, 1, 1, 0, 0, 0); // AL
    vecs[6]  = mk(1, 4'hF, 4'h8, 1, 0, 0, 1, 4'h2, 4'h8, 0, 1, 1, 0, 0); // push+update, CS old
    vecs[7]  = mk(0, 4'h0, 4'h0, 0, 1, 0, 1, 4'hF, 4'h1, 0, 1, 0, 0, 0); // pop restores, NV
    vecs[8]  = mk(1, 4'hF, 4'h2, 1, 0, 0, 0, 4'h0, 4'h2, 0, 0, 1, 0, 0);
    vecs[9]  = mk(1, 4'hF, 4'h3, 1, 0, 0, 0, 4'h0, 4'h3, 0, 0, 2, 0, 0);
    vecs[10] = mk(1, 4'hF, 4'h4, 1, 0, 0, 0, 4'h0, 4'h4, 0, 0, 3, 0, 0);
    vecs[11] = mk(1, 4'hF, 4'h5, 1, 0, 0, 0, 4'h0, 4'h5, 0, 0, 4, 0, 0); // full
    vecs[12] = mk(0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'h5, 0, 0, 4, 1, 0); // overflow
    vecs[13] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 4'h0, 4'h5, 0, 0, 4, 0, 0); // clr_err
    vecs[14] = mk(0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h4, 0, 0, 4, 0, 0); // swap when full
    vecs[15] = mk(0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h5, 0, 0, 3, 0, 0); // swapped-in top
    vecs[16] = mk(0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h3, 0, 0, 2, 0, 0);
    vecs[17] = mk(0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h2, 0, 0, 1, 0, 0);
    vecs[18] = mk(0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h1, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 4'h0, 4'h0, 0, 1, 0, 0, 4'h0, 4'h1, 0, 0, 0, 0, 1); // underflow
    vecs[20] = mk(0, 4'h0, 4'h0, 0, 1, 1, 0, 4'h0, 4'h1, 0, 0, 0, 0, 1); // set wins
    vecs[21] = mk(0, 4'h0, 4'h0, 0, 0, 1, 0, 4'h0, 4'h1, 0, 0, 0, 0, 0); // clear
    vecs[22] = mk(0, 4'h0, 4'h0, 1, 1, 0, 0, 4'h0, 4'h1, 0, 0, 0, 0, 1); // push+pop empty
    vecs[23] = mk(1, 4'hC, 4'hA, 0, 1, 0, 0, 4'h0, 4'h9, 0, 0, 0, 0, 1); // invalid pop, update applies
    vecs[24] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h8, 4'h9, 0, 1, 0, 0, 1); // HI
    vecs[25] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h9, 4'h9, 1, 1, 0, 0, 1); // LS
    vecs[26] = mk(1, 4'hF, 4'hC, 0, 0, 0, 0, 4'h0, 4'hC, 1, 0, 0, 0, 1);
    vecs[27] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'hA, 4'hC, 0, 1, 0, 0, 1); // GE
    vecs[28] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'hD, 4'hC, 1, 1, 0, 0, 1); // LE
    vecs[29] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h4, 4'hC, 1, 1, 0, 0, 1); // MI
    vecs[30] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h6, 4'hC, 0, 1, 0, 0, 1); // VS
    vecs[31] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h1, 4'hC, 1, 1, 0, 0, 1); // NE
    vecs[32] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h3, 4'hC, 0, 1, 0, 0, 1); // CC
    vecs[33] = mk(0, 4'h0, 4'h0, 0, 0, 0, 1, 4'h5, 4'hC, 0, 1, 0, 0, 1); // PL

    // Reset block
    drive_idle();
    reset = 1'b1;
    step();
    step();
    exp_q.push_back(pack_exp(4'h0, 0, 0, 3'd0, 0, 0));
    check("reset_state", obs0());
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive_vec(vecs[i]);
      step();
      exp_q.push_back(pack_exp(vecs[i].e_flags, vecs[i].e_take, vecs[i].e_tv,
                               vecs[i].e_depth, vecs[i].e_ovf, vecs[i].e_unf));
      check($sformatf("vec%0d", i), obs0());
    end
    drive_idle();

    // Asynchronous reset mid-operation: two pushes, then reset between edges.
    b0.push = 1'b1;
    step();
    step();
    drive_idle();
    exp_q.push_back(pack_exp(4'hC, 0, 0, 3'd2, 0, 1));
    check("pre_reset_depth", obs0());
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(pack_exp(4'h0, 0, 0, 3'd0, 0, 0));
    check("async_reset_fwd0", obs0());
    exp_q.push_back(pack_exp(4'h0, 0, 0, 3'd0, 0, 0));
    check("async_reset_fwd1", obs1());
    #1;
    reset = 1'b0;
    b0.pop = 1'b1;
    step();
    drive_idle();
    exp_q.push_back(pack_exp(4'h0, 0, 0, 3'd0, 0, 1));
    check("pop_after_reset", obs0());
    b0.clr_err = 1'b1;
    step();
    drive_idle();

    // Forwarding: update sets Z in the same cycle EQ is evaluated.
    b0.update = 1'b1; b0.flag_mask = 4'h1; b0.flags_in = 4'h1;
    b0.cond_valid = 1'b1; b0.cond = 4'h0;
    step();
    drive_idle();
    exp_q.push_back(pack_exp(4'h1, 0, 1, 3'd0, 0, 0));
    check("eq_fwd0", obs0());
    exp_q.push_back(pack_exp(4'h1, 1, 1, 3'd0, 0, 0));
    check("eq_fwd1", obs1());

    // Forwarding of a pop: push Z=1, clear Z, then pop with EQ in the same cycle.
    b0.push = 1'b1; b0.update = 1'b1; b0.flag_mask = 4'hF; b0.flags_in = 4'h0;
    step();
    drive_idle();
    b0.pop = 1'b1; b0.cond_valid = 1'b1; b0.cond = 4'h0;
    step();
    drive_idle();
    exp_q.push_back(pack_exp(4'h1, 0, 1, 3'd0, 0, 0));
    check("pop_eq_fwd0", obs0());
    exp_q.push_back(pack_exp(4'h1, 1, 1, 3'd0, 0, 0));
    check("pop_eq_fwd1", obs1());

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
